// File: rtl/fp_normalizer.sv
// Post-add normalisation stage of the single-precision FP adder.
// Shifts the adder magnitude one bit per cycle, adjusts the exponent and packs an IEEE-754 word.
module fp_normalizer #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    Sign,
  input  logic [EXP_W-1:0]        Exp,
  input  logic [MANT_W-1:0]       Mant,
  input  logic                    Cout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] Result,
  output logic                    Zero,
  output logic                    Overflow,
  output logic                    Underflow,
  output logic                    busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  logic [1:0]        r_state, w_state_d;
  logic              r_s, w_s_d;
  logic [EXP_W:0]    r_e, w_e_d;
  logic [MANT_W-1:0] r_m, w_m_d;
  logic              r_c, w_c_d;
  logic              r_zero, w_zero_d;
  logic              r_ovf, w_ovf_d;
  logic              r_unf, w_unf_d;

  always_comb begin
    w_state_d = r_state;
    w_s_d     = r_s;
    w_e_d     = r_e;
    w_m_d     = r_m;
    w_c_d     = r_c;
    w_zero_d  = r_zero;
    w_ovf_d   = r_ovf;
    w_unf_d   = r_unf;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_s_d     = Sign;
          w_e_d     = {1'b0, Exp};
          w_m_d     = Mant;
          w_c_d     = Cout;
          w_zero_d  = 1'b0;
          w_ovf_d   = 1'b0;
          w_unf_d   = 1'b0;
          w_state_d = NORM;
        end
      end
      NORM: begin
        w_state_d = DONE;
        if (r_e == EXP_MAX) begin
          w_ovf_d = 1'b1;
        end else if (r_c) begin
          // Carry-out: the hidden bit moves up one place; the dropped LSB is truncated.
          w_m_d   = {1'b1, r_m[MANT_W-1:1]};
          w_e_d   = r_e + EXP_ONE;
          w_c_d   = 1'b0;
          w_ovf_d = ((r_e + EXP_ONE) == EXP_MAX);
        end else if (r_m == '0) begin
          w_zero_d = 1'b1;
          w_s_d    = 1'b0;
          w_e_d    = '0;
        end else if (r_m[MANT_W-1]) begin
          w_unf_d = (r_e == '0);
        end else if (r_e <= EXP_ONE) begin
          w_unf_d = 1'b1;
        end else begin
          w_m_d     = r_m << 1;
          w_e_d     = r_e - EXP_ONE;
          w_state_d = NORM;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_zero_d  = 1'b0;
          w_ovf_d   = 1'b0;
          w_unf_d   = 1'b0;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s     <= 1'b0;
      r_e     <= '0;
      r_m     <= '0;
      r_c     <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_s     <= w_s_d;
      r_e     <= w_e_d;
      r_m     <= w_m_d;
      r_c     <= w_c_d;
      r_zero  <= w_zero_d;
      r_ovf   <= w_ovf_d;
      r_unf   <= w_unf_d;
    end
  end

  always_comb begin
    Result = '0;
    if (r_state == DONE) begin
      if (r_ovf) begin
        Result = {r_s, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      end else if (!(r_unf || r_zero)) begin
        Result = {r_s, r_e[EXP_W-1:0], r_m[MANT_W-2:0]};
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign Zero      = r_zero;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed table, corner sequences and random ops
// compared against an arithmetic reference model.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        Sign;
  logic [7:0]  Exp;
  logic [23:0] Mant;
  logic        Cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        Underflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_normalizer #(.EXP_W(8), .MANT_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sign      (Sign),
    .Exp       (Exp),
    .Mant      (Mant),
    .Cout      (Cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .busy      (busy)
  );

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic        c;
    logic [31:0] res;
    logic [2:0]  flags; // {Zero, Overflow, Underflow}
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: treat Cout:Mant as an integer magnitude and normalise it arithmetically.
  function automatic vec_t model(input logic s, input int e, input int m, input logic c);
    vec_t r;
    int mag, ne, f, lz;
    r.s = s; r.e = 8'(e); r.m = 24'(m); r.c = c;
    r.res = 32'h0; r.flags = 3'b000; r.lat = 2;
    if (e == 255) begin
      r.flags = 3'b010; r.res = {s, 8'hFF, 23'h0};
    end else if (c) begin
      mag = (1 << 24) + m;
      ne  = e + 1;
      if (ne == 255) begin
        r.flags = 3'b010; r.res = {s, 8'hFF, 23'h0};
      end else begin
        f = (mag >> 1) & 'h7FFFFF;
        r.res = {s, 8'(ne), 23'(f)};
      end
    end else if (m == 0) begin
      r.flags = 3'b100;
    end else begin
      lz = 0;
      while (((m << lz) & 'h800000) == 0) lz++;
      if (lz == 0) begin
        if (e == 0) r.flags = 3'b001;
        else begin
          f = m & 'h7FFFFF;
          r.res = {s, 8'(e), 23'(f)};
        end
      end else if (e <= 1) begin
        r.flags = 3'b001;
      end else if (lz <= e - 1) begin
        r.lat = 2 + lz;
        f = (m << lz) & 'h7FFFFF;
        r.res = {s, 8'(e - lz), 23'(f)};
      end else begin
        r.lat = 2 + (e - 1);
        r.flags = 3'b001;
      end
    end
    return r;
  endfunction

  // Present one operand, wait for out_valid, return what was observed (out_ready left as set).
  task automatic start_op(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c,
                          input logic rdy_during, output logic [31:0] res,
                          output logic [2:0] flags, output int lat, output logic busy_ok);
    Sign = s; Exp = e; Mant = m; Cout = c;
    in_valid  = 1'b1;
    out_ready = rdy_during;
    @(posedge clk); #1;
    in_valid = 1'b0;
    Sign = ~s; Exp = ~e; Mant = ~m; Cout = ~c; // garbage after accept must not matter
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy || in_ready) busy_ok = 1'b0;
    res   = Result;
    flags = {Zero, Overflow, Underflow};
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " idle"}, {out_valid, in_ready, busy, Zero, Overflow, Underflow},
          {1'b0, 1'b1, 1'b0, 3'b000});
  endtask

  task automatic run_check(input vec_t v, input string tag, input logic rdy_during);
    logic [31:0] res;
    logic [2:0]  flags;
    int          lat;
    logic        busy_ok;
    start_op(v.s, v.e, v.m, v.c, rdy_during, res, flags, lat, busy_ok);
    check({tag, " result"}, res, v.res);
    check({tag, " flags"}, flags, v.flags);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " busy"}, busy_ok, 1'b1);
    finish_op(tag);
  endtask

  vec_t tbl[11];

  initial begin
    logic [31:0] res, hres;
    logic [2:0]  flags;
    int          lat;
    logic        busy_ok;
    logic        stable;
    vec_t        v;
    int          em;

    tbl[0]  = '{1'b0, 8'd127, 24'h800000, 1'b0, 32'h3F800000, 3'b000, 2};
    tbl[1]  = '{1'b0, 8'd127, 24'h000000, 1'b1, 32'h40000000, 3'b000, 2};
    tbl[2]  = '{1'b1, 8'd127, 24'h000001, 1'b0, 32'hB4000000, 3'b000, 25};
    tbl[3]  = '{1'b1, 8'd140, 24'h000000, 1'b0, 32'h00000000, 3'b100, 2};
    tbl[4]  = '{1'b0, 8'd254, 24'h800000, 1'b1, 32'h7F800000, 3'b010, 2};
    tbl[5]  = '{1'b0, 8'd5,   24'h000100, 1'b0, 32'h00000000, 3'b001, 6};
    tbl[6]  = '{1'b1, 8'd255, 24'h123456, 1'b0, 32'hFF800000, 3'b010, 2};
    tbl[7]  = '{1'b0, 8'd0,   24'h800000, 1'b0, 32'h00000000, 3'b001, 2};
    tbl[8]  = '{1'b1, 8'd1,   24'h000001, 1'b0, 32'h00000000, 3'b001, 2};
    tbl[9]  = '{1'b0, 8'd200, 24'hC00000, 1'b1, 32'h64E00000, 3'b000, 2};
    tbl[10] = '{1'b0, 8'd2,   24'h400000, 1'b0, 32'h00800000, 3'b000, 3};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Sign = 1'b0; Exp = '0; Mant = '0; Cout = 1'b0;
    #22;
    check("reset state", {in_ready, out_valid, busy, Zero, Overflow, Underflow, Result},
          {1'b1, 5'b0, 32'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_check(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // Overflow result must hold while the consumer stalls.
    start_op(1'b0, 8'd254, 24'h800000, 1'b1, 1'b0, hres, flags, lat, busy_ok);
    check("hold first", {hres, flags}, {32'h7F800000, 3'b010});
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!out_valid || Result !== hres || {Zero, Overflow, Underflow} !== 3'b010) stable = 1'b0;
    end
    check("hold stable", stable, 1'b1);
    finish_op("hold");

    // Asynchronous reset during normalisation discards the operand.
    Sign = 1'b0; Exp = 8'd5; Mant = 24'h000100; Cout = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy before reset", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset outputs", {in_ready, out_valid, busy, Zero, Overflow, Underflow, Result},
          {1'b1, 5'b0, 32'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_check(tbl[2], "post reset", 1'b0);

    // out_ready held high while busy must not disturb the operation.
    run_check(tbl[10], "early ready", 1'b1);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       em = $urandom_range(0, 4);
        1:       em = $urandom_range(250, 255);
        default: em = $urandom_range(0, 255);
      endcase
      v = model(1'($urandom), em,
                int'($urandom & (32'h00FFFFFF >> $urandom_range(0, 24))),
                ($urandom_range(0, 3) == 0));
      run_check(v, $sformatf("rnd%0d", n), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_normalizer.md
Name: fp_normalizer

Overview:
- Post-add normalisation stage of the single-precision floating-point adder.
- Sits directly downstream of the 24-bit mantissa adder/subtractor and consumes its magnitude result (Sum or Difference), its Cout, the pre-aligned common exponent and the result sign.
- Iteratively normalises the mantissa, adjusts the exponent, detects zero/overflow/underflow and packs an IEEE-754 word.
- Uses a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width; all-ones is Inf, zero is flushed.
- MANT_W, 24, mantissa width including hidden bit; Result width is 1+EXP_W+MANT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream operand valid
- in_ready  output  1  block can accept an operand
- Sign  input  1  result sign from the add/sub stage
- Exp  input  EXP_W  common (larger) exponent after alignment
- Mant  input  MANT_W  adder magnitude output
- Cout  input  1  adder carry-out; 1 means the magnitude is Cout:Mant
- out_valid  output  1  Result and flags valid
- out_ready  input  1  downstream accepts the result
- Result  output  1+EXP_W+MANT_W-1  packed float {sign, exp, fraction}
- Zero  output  1  result is exactly zero
- Overflow  output  1  exponent saturated to all-ones (Inf)
- Underflow  output  1  result flushed to zero
- busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous active-low.
- Reset (any time, including mid-normalisation):
  - state returns to IDLE; in-flight operand is discarded;
  - in_ready=1; out_valid=0; Result=0; Zero=0; Overflow=0; Underflow=0; busy=0.
- Internal registers: s, e[EXP_W:0] (one guard bit), m[MANT_W-1:0], c.
- State IDLE:
  - in_ready=1.
  - When in_valid&&in_ready, capture Sign, Exp, Mant, Cout into s, e, m, c; go to NORM.
- State NORM: in_ready=0. Exactly one of the following per cycle, evaluated in priority order:
  1. e==all-ones (input already Inf range): set Overflow; go to DONE.
  2. c==1: m={1,m[MANT_W-1:1]} (LSB truncated); e=e+1; if the new e==all-ones, set Overflow; go to DONE.
  3. m==0: set Zero; force s=0, e=0; go to DONE.
  4. m[MANT_W-1]==1: if e==0, set Underflow (flush); go to DONE.
  5. Otherwise (m[MSB]==0):
     - if e<=1, set Underflow; go to DONE;
     - else m=m<<1, e=e-1; stay in NORM.
- State DONE:
  - out_valid=1.
  - Result packing:
    - Overflow set: Result={s, all-ones, 0}.
    - Underflow or Zero set: Result=0.
    - Otherwise: Result={s, e[EXP_W-1:0], m[MANT_W-2:0]}.
  - Result and flags are held stable while out_ready=0.
  - When out_valid&&out_ready, go to IDLE and clear out_valid and the flags next cycle.
- Flags: at most one of Zero/Overflow/Underflow is set per result.
- Rounding: truncation only, no rounding.
- Latency:
  - accept edge to out_valid high = 2+k cycles, where k is the number of left shifts (0..MANT_W-1);
  - the carry path is always 2 cycles.
- Throughput: one operation per 3+k cycles minimum.
- Handshake: in_ready is high only in IDLE, so there is no accept in the same cycle as an output handshake.
- in_valid while busy is ignored; upstream must hold its data.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Mant=24'h800000, Cout=0, Exp=127, Sign=0 -> Result=32'h3F800000, all flags 0, out_valid 2 cycles after accept.
- Mant=24'h000000, Cout=1, Exp=127, Sign=0 (1.0+1.0) -> Result=32'h40000000, latency 2.
- Mant=24'h000001, Cout=0, Exp=127, Sign=1 -> 23 shifts, Result=32'hB4000000, out_valid 25 cycles after accept, busy high throughout.
- Mant=0, Cout=0, Exp=140, Sign=1 (2222-2222) -> Result=32'h00000000, Zero=1.
- Mant=24'h800000, Cout=1, Exp=254, Sign=0 -> Overflow=1, Result=32'h7F800000.
  - Hold out_ready=0 for 5 cycles: Result stays stable.
  - Then out_ready=1: IDLE with in_ready=1 next cycle.
- Mant=24'h000100, Cout=0, Exp=5 -> Underflow=1, Result=0 after 4 shifts.
  - Separately, assert rst_n=0 after 3 cycles of NORM: outputs clear immediately, in_ready=1, and a following operand completes correctly.
